brq_fetch_aligner: RTL

- Instruction-fetch stage that drives the halfword-indexed ICCM read port and consumes its two 16-bit read halves.
- Assembles 16-bit (RV32C) or 32-bit instructions, advances the PC by 2 or 4, and presents registered instructions to decode over a valid/ready handshake.
- Handles pipeline redirects (branch/jump/trap) from execute.
- Sits between the ICCM and the decode stage of Buraq-mini.

---
 rtl/brq_fetch_aligner_pkg.sv | 10 +
 rtl/brq_fetch_aligner_if.sv | 33 +++
 rtl/brq_instr_align.sv | 27 ++
 rtl/brq_fetch_aligner.sv | 98 +++++++++
 4 files changed

// File: rtl/brq_fetch_aligner_pkg.sv
// Shared types and constants for the Buraq-mini fetch aligner.
package brq_fetch_pkg;

    typedef enum logic {IDLE, RUN} fetch_state_e;

    localparam logic [1:0] C_OPCODE_32 = 2'b11;
    localparam logic [2:0] PC_STEP_C   = 3'd2;
    localparam logic [2:0] PC_STEP_32  = 3'd4;

endpackage

// File: rtl/brq_fetch_aligner_if.sv
// ICCM read port and decode handshake of the fetch aligner, bundled with directional views.
interface brq_fetch_aligner_if #(
    parameter int DataWidth = 32,
    parameter int HalfWord  = 16,
    parameter int AddrWidth = 15
);
    logic                 fetch_en_i;
    logic [AddrWidth-1:0] iccm_addr_o;
    logic                 iccm_read_o;
    logic [HalfWord-1:0]  iccm_lsb_i;
    logic [HalfWord-1:0]  iccm_msb_i;
    logic                 redirect_i;
    logic [DataWidth-1:0] redirect_pc_i;
    logic [DataWidth-1:0] instr_o;
    logic [DataWidth-1:0] pc_o;
    logic                 instr_valid_o;
    logic                 instr_ready_i;
    logic                 is_compressed_o;
    logic                 illegal_o;

    // Fetch stage side
    modport master (
        input  fetch_en_i, iccm_lsb_i, iccm_msb_i, redirect_i, redirect_pc_i, instr_ready_i,
        output iccm_addr_o, iccm_read_o, instr_o, pc_o, instr_valid_o, is_compressed_o, illegal_o
    );

    // ICCM / decode / execute side
    modport slave (
        output fetch_en_i, iccm_lsb_i, iccm_msb_i, redirect_i, redirect_pc_i, instr_ready_i,
        input  iccm_addr_o, iccm_read_o, instr_o, pc_o, instr_valid_o, is_compressed_o, illegal_o
    );

endinterface

// File: rtl/brq_instr_align.sv
// Combinational RV32C/RV32I instruction assembly from two consecutive ICCM halfwords.
module brq_instr_align #(
    parameter int DataWidth = 32,
    parameter int HalfWord  = 16
) (
    input  logic [HalfWord-1:0]  lsb,
    input  logic [HalfWord-1:0]  msb,
    output logic [DataWidth-1:0] instr,
    output logic                 comp,
    output logic                 illegal,
    output logic [2:0]           step
);
    import brq_fetch_pkg::*;

    always_comb begin
        comp    = (lsb[1:0] != C_OPCODE_32);
        illegal = (lsb == '0);
        if (comp) begin
            instr = {{(DataWidth-HalfWord){1'b0}}, lsb};
            step  = PC_STEP_C;
        end else begin
            instr = {msb, lsb};
            step  = PC_STEP_32;
        end
    end

endmodule

// File: rtl/brq_fetch_aligner.sv
// Fetch stage: drives the ICCM halfword port, aligns 16/32-bit instructions, registers them for decode.
//  state | meaning
//  IDLE  | core disabled, no ICCM reads, held output may still drain
//  RUN   | fetching one instruction per accepted handshake
module brq_fetch_aligner #(
    parameter int                  DataWidth = 32,
    parameter int                  HalfWord  = 16,
    parameter int                  AddrWidth = 15,
    parameter logic [DataWidth-1:0] BootAddr = 32'h0000_0000
) (
    input  logic                brq_clk,
    input  logic                brq_rst,
    brq_fetch_aligner_if.master bus
);
    import brq_fetch_pkg::*;

    fetch_state_e         state, state_next;
    logic [DataWidth-1:0] pc;
    logic [DataWidth-1:0] instr_q;
    logic [DataWidth-1:0] pc_q;
    logic                 valid_q;
    logic                 comp_q;
    logic                 illegal_q;

    logic [DataWidth-1:0] align_instr;
    logic                 align_comp;
    logic                 align_illegal;
    logic [2:0]           align_step;
    logic                 fire;

    brq_instr_align #(
        .DataWidth (DataWidth),
        .HalfWord  (HalfWord)
    ) u_align (
        .lsb     (bus.iccm_lsb_i),
        .msb     (bus.iccm_msb_i),
        .instr   (align_instr),
        .comp    (align_comp),
        .illegal (align_illegal),
        .step    (align_step)
    );

    assign fire = (state == RUN) && !bus.redirect_i && (!valid_q || bus.instr_ready_i);

    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.fetch_en_i)  state_next = RUN;
            RUN:     if (!bus.fetch_en_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Redirect flushes the held instruction; a same-cycle valid&&ready transfer is still consumed by decode.
    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            pc        <= BootAddr;
            instr_q   <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            comp_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (bus.redirect_i) begin
            pc      <= {bus.redirect_pc_i[DataWidth-1:1], 1'b0};
            valid_q <= 1'b0;
        end else if (fire) begin
            instr_q   <= align_instr;
            pc_q      <= pc;
            comp_q    <= align_comp;
            illegal_q <= align_illegal;
            valid_q   <= 1'b1;
            pc        <= pc + {{(DataWidth-3){1'b0}}, align_step};
        end else if (valid_q && bus.instr_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Upper pc bits travel with pc_o but never reach the ICCM index, so addresses wrap at the array edge.
    assign bus.iccm_addr_o     = pc[AddrWidth:1];
    assign bus.iccm_read_o     = (state == RUN);
    assign bus.instr_o         = instr_q;
    assign bus.pc_o            = pc_q;
    assign bus.instr_valid_o   = valid_q;
    assign bus.is_compressed_o = comp_q;
    assign bus.illegal_o       = illegal_q;

    logic unused_bits;
    assign unused_bits = ^{pc[DataWidth-1:AddrWidth+1], pc[0], bus.redirect_pc_i[0]};

endmodule
